// File: rtl/imem_loader.sv
// Byte-stream programmer for the instruction memory write port.
// Parses framed load commands and emits one registered byte write per accepted data byte.
module imem_loader #(
  parameter int         MEM_BYTES = 1024,
  parameter logic [7:0] CMD_LOAD  = 8'h01
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        s_valid_i,
  input  logic [7:0]  s_data_i,
  output logic        s_ready_o,
  output logic        we_o,
  output logic [63:0] waddr_o,
  output logic [7:0]  wdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_B0, ST_B1, ST_L0, ST_L1, ST_DATA, ST_CSUM, ST_REPORT
  } state_e;

  localparam logic [16:0] MEM_LIMIT = 17'(MEM_BYTES);

  state_e      state_q, state_d;
  logic [15:0] base_q, base_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  logic        range_bad_q, range_bad_d;
  logic        csum_bad_q, csum_bad_d;
  logic        we_q, we_d;
  logic [63:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;

  logic        accept;
  logic [15:0] len_full;
  logic [16:0] frame_end;

  assign s_ready_o = (state_q != ST_REPORT);
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_REPORT);
  assign err_o     = (state_q == ST_REPORT) & (range_bad_q | csum_bad_q);

  assign accept    = s_valid_i & s_ready_o;
  assign len_full  = {s_data_i, len_lo_q};
  // 17-bit sum so a frame running past the top of a 16-bit base cannot wrap into range.
  assign frame_end = {1'b0, base_q} + {1'b0, len_full};

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d     = state_q;
    base_d      = base_q;
    len_lo_d    = len_lo_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    range_bad_d = range_bad_q;
    csum_bad_d  = csum_bad_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept && s_data_i == CMD_LOAD) begin
          state_d     = ST_B0;
          sum_d       = 8'd0;
          range_bad_d = 1'b0;
          csum_bad_d  = 1'b0;
        end
      end
      ST_B0: begin
        if (accept) begin
          base_d  = {base_q[15:8], s_data_i};
          sum_d   = sum_q + s_data_i;
          state_d = ST_B1;
        end
      end
      ST_B1: begin
        if (accept) begin
          base_d  = {s_data_i, base_q[7:0]};
          sum_d   = sum_q + s_data_i;
          state_d = ST_L0;
        end
      end
      ST_L0: begin
        if (accept) begin
          len_lo_d = s_data_i;
          sum_d    = sum_q + s_data_i;
          state_d  = ST_L1;
        end
      end
      ST_L1: begin
        if (accept) begin
          sum_d       = sum_q + s_data_i;
          rem_d       = len_full;
          idx_d       = 16'd0;
          range_bad_d = (frame_end > MEM_LIMIT);
          state_d     = (len_full == 16'd0) ? ST_CSUM : ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          // Out-of-range frames still drain their data bytes, just without writing.
          we_d    = ~range_bad_q;
          waddr_d = 64'(base_q) + 64'(idx_q);
          wdata_d = s_data_i;
          sum_d   = sum_q + s_data_i;
          idx_d   = idx_q + 16'd1;
          rem_d   = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (accept) begin
          csum_bad_d = (s_data_i != sum_q);
          state_d    = ST_REPORT;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (rst_i) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_lo_q    <= '0;
      rem_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      range_bad_q <= 1'b0;
      csum_bad_q  <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_lo_q    <= len_lo_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      range_bad_q <= range_bad_d;
      csum_bad_q  <= csum_bad_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign we_o    = we_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;

endmodule
